// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of up to COUNT unsigned products from the
// array multiplier and presents each group sum on a valid/ready output.
// Each group ends after COUNT beats, or earlier on an accepted beat with
// in_last set. Only one group is ever in flight: while a finished result waits
// in HOLD, no input is taken, so a new group cannot start until the consumer
// has taken the previous result.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4,
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_sum_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_ovf_q;

  // Post-add values for the current beat; the extra MSB of the sum is the carry.
  logic [ACC_W:0]     add_d;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_d;
  logic               grp_end_d;

  // Next accumulator/counter/flag values if this cycle's beat is accepted.
  always_comb begin
    add_d     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    acc_d     = add_d[ACC_W-1:0];
    ovf_d     = ovf_q | add_d[ACC_W];
    cnt_d     = cnt_q + CNT_W'(1);
    // in_last on the COUNT-th beat is the same group end, not a second one.
    grp_end_d = (cnt_d == COUNT_C) | in_last;
  end

  // Group FSM: accumulate in ACCUM, present the result in HOLD until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (grp_end_d) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_sum_q   <= acc_d;
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
            end
          end
        end
        HOLD: begin
          // Result registers keep their value after the handshake; only the
          // running state is cleared for the next group.
          if (out_ready) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default instance (ACC_W=16,
// COUNT=4) and a narrow instance (ACC_W=9) for the wrap/overflow case.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;

  // Default instance
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_overflow;
  logic [7:0]  in_product;
  logic [15:0] out_sum;
  logic [2:0]  out_count;

  // Narrow-accumulator instance
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_overflow;
  logic [7:0]  b_in_product;
  logic [8:0]  b_out_sum;
  logic [2:0]  b_out_count;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_count(b_out_count), .out_overflow(b_out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] p, input logic l);
    in_valid = 1'b1; in_product = p; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] p);
    b_in_valid = 1'b1; b_in_product = p; b_in_last = 1'b0;
    step();
    b_in_valid = 1'b0;
  endtask

  initial begin
    int lows;
    rst = 1'b1;
    in_valid = 0; in_product = 0; in_last = 0; out_ready = 1;
    b_in_valid = 0; b_in_product = 0; b_in_last = 0; b_out_ready = 1;

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_sum",   out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf",   out_overflow, 0);
    step();
    rst = 1'b0;

    // 1: four full-scale-ish products back to back
    in_valid = 1; in_product = 225;
    repeat (3) step();
    chk("t1_not_yet_valid", out_valid, 0);
    step();
    in_valid = 0;
    chk("t1_valid", out_valid, 1);
    chk("t1_in_ready_low", in_ready, 0);
    chk("t1_sum", out_sum, 900);
    chk("t1_count", out_count, 4);
    chk("t1_ovf", out_overflow, 0);
    step();
    chk("t1_valid_fall", out_valid, 0);
    chk("t1_in_ready_back", in_ready, 1);

    // 2: early end with in_last
    beat(10, 0);
    chk("t2_mid_valid", out_valid, 0);
    beat(20, 1);
    chk("t2_valid", out_valid, 1);
    chk("t2_sum", out_sum, 30);
    chk("t2_count", out_count, 2);
    step();

    // in_last on the COUNT-th beat is a single group end
    beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 1);
    chk("tl_sum", out_sum, 4);
    chk("tl_count", out_count, 4);
    step();
    chk("tl_valid_fall", out_valid, 0);
    beat(9, 1);
    chk("tl_single_sum", out_sum, 9);
    chk("tl_single_count", out_count, 1);
    step();

    // 3: backpressure in HOLD with input offered
    out_ready = 0;
    beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 0);
    chk("t3_sum", out_sum, 10);
    in_valid = 1; in_product = 7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_sum", out_sum, 10);
      chk("t3_hold_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    step();
    chk("t3_release", out_valid, 0);
    beat(5, 0); beat(6, 1);
    chk("t3_next_sum", out_sum, 11);
    chk("t3_next_count", out_count, 2);
    step();

    // 4: narrow accumulator wraps and flags overflow
    b_beat(255); b_beat(255); b_beat(255); b_beat(1);
    chk("t4_valid", b_out_valid, 1);
    chk("t4_sum", b_out_sum, 254);
    chk("t4_ovf", b_out_overflow, 1);
    chk("t4_count", b_out_count, 4);
    step();
    chk("t4_valid_fall", b_out_valid, 0);

    // 5: asynchronous reset mid-group
    beat(1, 0); beat(2, 0);
    #3 rst = 1'b1;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_sum", out_sum, 0);
    chk("t5_count", out_count, 0);
    chk("t5_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 0);
    chk("t5_next_sum", out_sum, 10);
    chk("t5_next_count", out_count, 4);
    step();

    // 6: continuous streaming, one result every 5 cycles
    lows = 0;
    in_valid = 1; in_product = 1; in_last = 0; out_ready = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("t6_valid_pattern", out_valid, ((i % 5) == 4) ? 1 : 0);
      if (!in_ready) lows++;
      if (out_valid) chk("t6_sum", out_sum, 4);
    end
    in_valid = 0;
    chk("t6_ready_low_cycles", lows, 4);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
